sw_ctrl: RTL
============

Name: sw_ctrl

Overview:
- Memory-mapped switch-input peripheral on the core data bus; sits upstream of the interrupt controller.
- Synchronises and debounces SW_WIDTH board switches and exposes the stable value plus sticky per-bit change flags to the core.
- Raises an interrupt request on the line the interrupt controller samples, and clears the serviced flags on the controller's finish pulse.
- The address decoder supplies the write strobe; read data feeds the top-level read mux.

Parameters:
- SW_WIDTH, 16, number of switch inputs (1..32).
- DEBOUNCE_CYCLES, 100000, consecutive stable clk_i cycles before a new value is accepted (>=2).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset
- sw_i  in  SW_WIDTH  raw asynchronous switch levels
- req_i  in  1  bus request, already qualified by the address decoder for this peripheral
- we_i  in  1  write enable, valid with req_i
- addr_i  in  32  byte address; only addr_i[3:2] decoded
- be_i  in  4  byte enables for writes
- wdata_i  in  32  write data
- rdata_o  out  32  read data, combinational from addr_i
- int_req_o  out  1  interrupt request to the interrupt controller
- int_fin_i  in  1  one-cycle completion pulse from the interrupt controller

Interface (already decided): one clock, clk_i. Reset rst_n_i is asynchronous and active-low.

Behaviour:
- Reset (rst_n_i=0, asynchronous): sync flops, candidate, counter, STATE, CHANGED, IRQ_EN and CTRL all 0; FSM in IDLE; int_req_o=0; rdata_o follows addr_i with zeroed registers.
- Synchroniser: two-flop chain per bit, giving sync_q. Raw-to-sync_q latency is 2 cycles.
- Debounce FSM, one shared counter (width $clog2(DEBOUNCE_CYCLES)):
  - IDLE: if sync_q != STATE, go to SETTLE with candidate <= sync_q and cnt <= 0.
  - SETTLE, sync_q != candidate: candidate <= sync_q, cnt <= 0, stay in SETTLE (restart on any bounce).
  - SETTLE, sync_q == candidate and cnt == DEBOUNCE_CYCLES-1: STATE <= candidate, CHANGED |= (STATE ^ candidate), go to IDLE.
  - SETTLE, otherwise: cnt++.
  - SETTLE, candidate == STATE (bounce back to the original value): go to IDLE with no flags set.
- STATE latency: a clean edge reaches STATE 2+DEBOUNCE_CYCLES cycles after sw_i changes.
- Register map (word offset = addr_i[3:2]); bits >= SW_WIDTH read 0 and ignore writes:
  - 0 STATE: read-only, debounced value.
  - 1 CHANGED: sticky flags, write-1-to-clear per bit.
  - 2 IRQ_EN: read/write, per-bit interrupt mask.
  - 3 CTRL: read/write, bit0 = global interrupt enable; other bits read 0.
- Writes: take effect on the clk_i edge where req_i & we_i; byte lane k is written only when be_i[k]. Writes with req_i=0 are ignored.
- CHANGED priority: a debounce set and a same-cycle W1C or int_fin_i clear on the same bit resolve to set (a new event is never lost).
- int_fin_i: on a pulse, CHANGED <= CHANGED & ~IRQ_EN (clears only the flags that could have caused the request).
- int_req_o: registered, int_req_o <= CTRL[0] & |(CHANGED & IRQ_EN). Asserts 1 cycle after the flag/enable condition becomes true; level, held until the condition is false.
- Reads have no side effects. rdata_o is valid combinationally regardless of req_i.

Test Plan (DEBOUNCE_CYCLES=4, SW_WIDTH=16):
- Reset with sw_i=16'h00FF, then hold -> after 2+4 cycles STATE reads 0x00FF and CHANGED reads 0x00FF; int_req_o stays 0 (IRQ_EN=0).
- Bounce: toggle sw_i[3] every 2 cycles for 20 cycles, then hold 1 -> STATE[3] updates exactly 6 cycles after the last toggle; no earlier update.
- Bounce-back: sw_i[0] goes 0->1->0, each level held 2 cycles -> FSM returns to IDLE; STATE and CHANGED unchanged.
- Interrupt: write IRQ_EN=0x0001, CTRL=1, clear CHANGED, flip sw_i[0] -> int_req_o=1 one cycle after CHANGED[0] sets. int_fin_i pulse -> CHANGED[0]=0 and int_req_o=0 the following cycle. A flagged bit 5 with IRQ_EN[5]=0 stays set.
- W1C collision: a write of 0x0002 to CHANGED lands in the same cycle the debounce sets bit 1 -> CHANGED[1] remains 1.
- Byte enables and reset: a write of 0xFFFF to IRQ_EN with be_i=4'b0010 reads back 0xFF00. Asserting rst_n_i mid-SETTLE clears all registers and int_req_o at once, with no clk_i edge needed.

Source files
------------

// File: rtl/sw_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : sw_ctrl_if
// Description : Core data-bus and interrupt handshake bundle for sw_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sw_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        int_req_o;
  logic        int_fin_i;

  modport slave (
    input  req_i,
    input  we_i,
    input  addr_i,
    input  be_i,
    input  wdata_i,
    input  int_fin_i,
    output rdata_o,
    output int_req_o
  );

  modport master (
    output req_i,
    output we_i,
    output addr_i,
    output be_i,
    output wdata_i,
    output int_fin_i,
    input  rdata_o,
    input  int_req_o
  );
endinterface

`default_nettype wire

// File: rtl/sw_ctrl.sv
//------------------------------------------------------------------------------
// Module      : sw_ctrl
// Description : Debounced switch-input peripheral with sticky change flags
//               and a maskable interrupt request.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sw_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  sw_ctrl_if.slave            bus
);

  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
  // The FSM's entry/restart cycle already sees the candidate once, so the
  // counter only has to cover the remaining DEBOUNCE_CYCLES-1 samples.
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 2);

  localparam logic [1:0] c_OFS_STATE   = 2'd0;
  localparam logic [1:0] c_OFS_CHANGED = 2'd1;
  localparam logic [1:0] c_OFS_IRQ_EN  = 2'd2;
  localparam logic [1:0] c_OFS_CTRL    = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } fsm_t;

  fsm_t                r_fsm;
  logic [SW_WIDTH-1:0] r_sync_meta;
  logic [SW_WIDTH-1:0] r_sync_q;
  logic [SW_WIDTH-1:0] r_cand;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [SW_WIDTH-1:0] r_sw_state;
  logic [SW_WIDTH-1:0] r_changed;
  logic [SW_WIDTH-1:0] r_irq_en;
  logic                r_ctrl_gie;
  logic                r_int_req;

  logic [31:0]         w_be_mask;
  logic [31:0]         w_wdata_be;
  logic                w_wr;
  logic                w_wr_changed;
  logic                w_wr_irq_en;
  logic                w_wr_ctrl;
  logic [SW_WIDTH-1:0] w_chg_clr;
  logic [31:0]         w_state_ext;
  logic [31:0]         w_changed_ext;
  logic [31:0]         w_irq_en_ext;
  logic                w_unused;

  for (genvar k = 0; k < 4; k++) begin : g_be
    assign w_be_mask[8*k +: 8] = {8{bus.be_i[k]}};
  end

  assign w_wdata_be   = bus.wdata_i & w_be_mask;
  assign w_wr         = bus.req_i & bus.we_i;
  assign w_wr_changed = w_wr && (bus.addr_i[3:2] == c_OFS_CHANGED);
  assign w_wr_irq_en  = w_wr && (bus.addr_i[3:2] == c_OFS_IRQ_EN);
  assign w_wr_ctrl    = w_wr && (bus.addr_i[3:2] == c_OFS_CTRL);

  assign w_chg_clr = (w_wr_changed ? w_wdata_be[SW_WIDTH-1:0] : '0)
                   | (bus.int_fin_i ? r_irq_en : '0);

  assign w_unused = ^{bus.addr_i[31:4], bus.addr_i[1:0], w_wdata_be};

  // Synchroniser, debounce FSM, debounced value and sticky change flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fsm       <= ST_IDLE;
      r_sync_meta <= '0;
      r_sync_q    <= '0;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_sw_state  <= '0;
      r_changed   <= '0;
    end else begin
      r_sync_meta <= sw_i;
      r_sync_q    <= r_sync_meta;
      r_changed   <= r_changed & ~w_chg_clr;
      case (r_fsm)
        ST_IDLE: begin
          if (r_sync_q != r_sw_state) begin
            r_fsm  <= ST_SETTLE;
            r_cand <= r_sync_q;
            r_cnt  <= '0;
          end
        end
        ST_SETTLE: begin
          if (r_sync_q != r_cand) begin
            r_cand <= r_sync_q;
            r_cnt  <= '0;
          end else if (r_cand == r_sw_state) begin
            r_fsm <= ST_IDLE;
          end else if (r_cnt == c_CNT_LAST) begin
            // New events win over a same-cycle clear.
            r_sw_state <= r_cand;
            r_changed  <= (r_changed & ~w_chg_clr) | (r_sw_state ^ r_cand);
            r_fsm      <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_irq_en   <= '0;
      r_ctrl_gie <= 1'b0;
      r_int_req  <= 1'b0;
    end else begin
      if (w_wr_irq_en) begin
        r_irq_en <= (r_irq_en & ~w_be_mask[SW_WIDTH-1:0]) | w_wdata_be[SW_WIDTH-1:0];
      end
      if (w_wr_ctrl && bus.be_i[0]) begin
        r_ctrl_gie <= bus.wdata_i[0];
      end
      r_int_req <= r_ctrl_gie & (|(r_changed & r_irq_en));
    end
  end

  assign bus.int_req_o = r_int_req;

  always_comb begin
    w_state_ext                  = '0;
    w_changed_ext                = '0;
    w_irq_en_ext                 = '0;
    w_state_ext[SW_WIDTH-1:0]    = r_sw_state;
    w_changed_ext[SW_WIDTH-1:0]  = r_changed;
    w_irq_en_ext[SW_WIDTH-1:0]   = r_irq_en;
  end

  always_comb begin
    bus.rdata_o = '0;
    case (bus.addr_i[3:2])
      c_OFS_STATE:   bus.rdata_o = w_state_ext;
      c_OFS_CHANGED: bus.rdata_o = w_changed_ext;
      c_OFS_IRQ_EN:  bus.rdata_o = w_irq_en_ext;
      c_OFS_CTRL:    bus.rdata_o = {31'd0, r_ctrl_gie};
      default:       bus.rdata_o = '0;
    endcase
  end

endmodule

`default_nettype wire
